// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared ISA decode constants, FSM state encodings and the source-register record
// used by the pipeline hazard controller.
package pipeline_hazard_ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_JR    = 5'b00100;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RD_MSB  = 26;
    localparam int RD_LSB  = 22;
    localparam int RS_MSB  = 21;
    localparam int RS_LSB  = 17;
    localparam int RT_MSB  = 16;
    localparam int RT_LSB  = 12;
    localparam int ALU_MSB = 6;
    localparam int ALU_LSB = 2;

    localparam logic [0:0] ST_RUN     = 1'b0;
    localparam logic [0:0] ST_MD_WAIT = 1'b1;

    typedef struct packed {
        logic [4:0] num;
        logic       vld;
    } src_reg_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_src_reg_decode.sv
// Extracts the registers an FD-stage instruction reads; the valid bit says whether
// the field is a real source for that instruction class.
module src_reg_decode
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [31:0] i_instr,
    output src_reg_t    o_rs,
    output src_reg_t    o_rt,
    output src_reg_t    o_rd
);

    logic [4:0] w_op;
    logic       w_unused_low;

    assign w_op = i_instr[OPC_MSB:OPC_LSB];

    // Stores and branches/jr read rd rather than writing it.
    assign o_rs = '{num: i_instr[RS_MSB:RS_LSB], vld: 1'b1};
    assign o_rt = '{num: i_instr[RT_MSB:RT_LSB], vld: (w_op == OP_RTYPE)};
    assign o_rd = '{num: i_instr[RD_MSB:RD_LSB],
                    vld: (w_op == OP_SW) || (w_op == OP_BNE) ||
                         (w_op == OP_BLT) || (w_op == OP_JR)};

    assign w_unused_low = ^i_instr[11:0];

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline latch sequencer: load-use bubbles, branch flushes and multdiv holds
// with a watchdog, plus a count of PC-stalled cycles.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 6
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_instr,
    input  logic [31:0] dx_instr,
    input  logic        branch_taken,
    input  logic        md_ready,
    output logic        pc_enable,
    output logic        fd_enable,
    output logic        fd_clear,
    output logic        dx_enable,
    output logic        dx_clear,
    output logic        xm_clear,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_timeout,
    output logic [31:0] stall_cycles
);

    // state      | meaning
    // ST_RUN     | normal flow; bubbles/flushes decided per cycle
    // ST_MD_WAIT | pipe frozen until md_ready or watchdog expiry

    logic [0:0]       r_state;
    logic [0:0]       w_next_state;
    logic [CNT_W-1:0] r_md_cnt;
    logic [31:0]      r_stall_cnt;

    src_reg_t   w_fd_rs;
    src_reg_t   w_fd_rt;
    src_reg_t   w_fd_rd;
    logic [4:0] w_dx_op;
    logic [4:0] w_dx_rd;
    logic [4:0] w_dx_alu;
    logic       w_dx_is_md;
    logic       w_dx_is_lw;
    logic       w_load_use;
    logic       w_md_expired;
    logic       w_unused_dx;

    src_reg_decode u_src_reg_decode (
        .i_instr (fd_instr),
        .o_rs    (w_fd_rs),
        .o_rt    (w_fd_rt),
        .o_rd    (w_fd_rd)
    );

    assign w_dx_op     = dx_instr[OPC_MSB:OPC_LSB];
    assign w_dx_rd     = dx_instr[RD_MSB:RD_LSB];
    assign w_dx_alu    = dx_instr[ALU_MSB:ALU_LSB];
    assign w_unused_dx = ^{dx_instr[RS_MSB:7], dx_instr[1:0]};

    assign w_dx_is_md = (w_dx_op == OP_RTYPE) &&
                        ((w_dx_alu == ALU_MUL) || (w_dx_alu == ALU_DIV));
    assign w_dx_is_lw = (w_dx_op == OP_LW);

    assign w_load_use = w_dx_is_lw && (w_dx_rd != 5'd0) &&
                        ((w_fd_rs.vld && (w_fd_rs.num == w_dx_rd)) ||
                         (w_fd_rt.vld && (w_fd_rt.num == w_dx_rd)) ||
                         (w_fd_rd.vld && (w_fd_rd.num == w_dx_rd)));

    assign w_md_expired = (r_md_cnt == CNT_W'(MD_TIMEOUT - 1));

    always_comb begin
        pc_enable    = 1'b1;
        fd_enable    = 1'b1;
        fd_clear     = 1'b0;
        dx_enable    = 1'b1;
        dx_clear     = 1'b0;
        xm_clear     = 1'b0;
        md_start     = 1'b0;
        md_busy      = 1'b0;
        md_timeout   = 1'b0;
        w_next_state = r_state;
        if (reset) begin
            pc_enable    = 1'b0;
            fd_enable    = 1'b0;
            dx_enable    = 1'b0;
            fd_clear     = 1'b1;
            dx_clear     = 1'b1;
            xm_clear     = 1'b1;
            w_next_state = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (branch_taken) begin
                        fd_clear = 1'b1;
                        dx_clear = 1'b1;
                    end else if (w_dx_is_md) begin
                        md_start     = 1'b1;
                        pc_enable    = 1'b0;
                        fd_enable    = 1'b0;
                        dx_enable    = 1'b0;
                        xm_clear     = 1'b1;
                        w_next_state = ST_MD_WAIT;
                    end else if (w_load_use) begin
                        pc_enable = 1'b0;
                        fd_enable = 1'b0;
                        dx_clear  = 1'b1;
                    end
                end
                default: begin
                    md_busy = 1'b1;
                    // Release lets XM capture the mul/div; the watchdog only flags when md_ready is absent.
                    if (md_ready || w_md_expired) begin
                        md_timeout   = ~md_ready;
                        w_next_state = ST_RUN;
                    end else begin
                        pc_enable = 1'b0;
                        fd_enable = 1'b0;
                        dx_enable = 1'b0;
                        xm_clear  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_md_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_RUN) begin
                r_md_cnt <= '0;
            end else begin
                r_md_cnt <= r_md_cnt + 1'b1;
            end
            if (!pc_enable) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected latch controls and stall count
// are queued at drive time and checked mid-cycle.
module tb_pipeline_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] fd_instr = '0;
    logic [31:0] dx_instr = '0;
    logic        branch_taken = 1'b0;
    logic        md_ready = 1'b0;
    logic        pc_enable, fd_enable, fd_clear, dx_enable, dx_clear, xm_clear;
    logic        md_start, md_busy, md_timeout;
    logic [31:0] stall_cycles;

    always #5 clock = ~clock;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(6)) dut (
        .clock        (clock),
        .reset        (reset),
        .fd_instr     (fd_instr),
        .dx_instr     (dx_instr),
        .branch_taken (branch_taken),
        .md_ready     (md_ready),
        .pc_enable    (pc_enable),
        .fd_enable    (fd_enable),
        .fd_clear     (fd_clear),
        .dx_enable    (dx_enable),
        .dx_clear     (dx_clear),
        .xm_clear     (xm_clear),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .md_timeout   (md_timeout),
        .stall_cycles (stall_cycles)
    );

    // {pc_en, fd_en, fd_clr, dx_en, dx_clr, xm_clr, md_start, md_busy, md_timeout}
    localparam logic [8:0] C_RST  = 9'b0_0_1_0_1_1_0_0_0;
    localparam logic [8:0] C_NORM = 9'b1_1_0_1_0_0_0_0_0;
    localparam logic [8:0] C_LU   = 9'b0_0_0_1_1_0_0_0_0;
    localparam logic [8:0] C_BR   = 9'b1_1_1_1_1_0_0_0_0;
    localparam logic [8:0] C_MDS  = 9'b0_0_0_0_0_1_1_0_0;
    localparam logic [8:0] C_MDW  = 9'b0_0_0_0_0_1_0_1_0;
    localparam logic [8:0] C_REL  = 9'b1_1_0_1_0_0_0_1_0;
    localparam logic [8:0] C_TMO  = 9'b1_1_0_1_0_0_0_1_1;

    typedef struct {
        string       tag;
        logic [8:0]  ctl;
        logic [31:0] stall;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_stall = '0;
    logic [8:0]  w_obs;

    assign w_obs = {pc_enable, fd_enable, fd_clear, dx_enable, dx_clear, xm_clear,
                    md_start, md_busy, md_timeout};

    function automatic logic [31:0] ins(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] alu);
        return {op, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    task automatic step(input string tag, input logic rst, input logic br, input logic rdy,
                        input logic [31:0] fd, input logic [31:0] dx, input logic [8:0] ctl);
        exp_t e;
        @(posedge clock);
        #1;
        reset        = rst;
        branch_taken = br;
        md_ready     = rdy;
        fd_instr     = fd;
        dx_instr     = dx;
        e.tag   = tag;
        e.ctl   = ctl;
        e.stall = exp_stall;
        sb.push_back(e);
        if (rst) exp_stall = '0;
        else if (!ctl[8]) exp_stall = exp_stall + 32'd1;
        @(negedge clock);
        e = sb.pop_front();
        total++;
        assert (w_obs === e.ctl) else begin
            bad++;
            $error("FAIL %s ctl: got %b want %b", e.tag, w_obs, e.ctl);
        end
        total++;
        assert (stall_cycles === e.stall) else begin
            bad++;
            $error("FAIL %s stall_cycles: got %0d want %0d", e.tag, stall_cycles, e.stall);
        end
    endtask

    initial begin
        logic [31:0] nop, mul, dv, bne, add565, add607, add617, addi7, sw9;
        nop    = '0;
        mul    = ins(5'b00000, 5'd1, 5'd2, 5'd3, 5'b00110);
        dv     = ins(5'b00000, 5'd4, 5'd2, 5'd3, 5'b00111);
        bne    = ins(5'b00010, 5'd1, 5'd2, 5'd0, 5'd0);
        add565 = ins(5'b00000, 5'd6, 5'd5, 5'd7, 5'd0);
        add607 = ins(5'b00000, 5'd6, 5'd0, 5'd7, 5'd0);
        add617 = ins(5'b00000, 5'd6, 5'd1, 5'd7, 5'd0);
        addi7  = ins(5'b00101, 5'd7, 5'd1, 5'd7, 5'd0);
        sw9    = ins(5'b00111, 5'd9, 5'd1, 5'd0, 5'd0);

        step("reset0", 1, 0, 0, nop, nop, C_RST);
        step("reset1", 1, 0, 0, nop, nop, C_RST);
        step("run_idle", 0, 0, 0, nop, nop, C_NORM);

        step("lu_rs", 0, 0, 0, add565, ins(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0), C_LU);
        step("lu_after", 0, 0, 0, add565, nop, C_NORM);
        step("lw_r0", 0, 0, 0, add607, ins(5'b01000, 5'd0, 5'd1, 5'd0, 5'd0), C_NORM);
        step("lu_rt", 0, 0, 0, add617, ins(5'b01000, 5'd7, 5'd1, 5'd0, 5'd0), C_LU);
        step("rt_not_src", 0, 0, 0, addi7, ins(5'b01000, 5'd7, 5'd2, 5'd0, 5'd0), C_NORM);
        step("lu_sw_rd", 0, 0, 0, sw9, ins(5'b01000, 5'd9, 5'd1, 5'd0, 5'd0), C_LU);
        step("lu_clear", 0, 0, 0, sw9, nop, C_NORM);

        step("br_flush", 0, 1, 0, ins(5'b01000, 5'd3, 5'd1, 5'd0, 5'd0), bne, C_BR);
        step("br_over_lu", 0, 1, 0, add565, ins(5'b01000, 5'd5, 5'd1, 5'd0, 5'd0), C_BR);
        step("br_over_md", 0, 1, 0, nop, mul, C_BR);
        step("br_after", 0, 0, 0, nop, nop, C_NORM);

        step("mul_start", 0, 0, 0, nop, mul, C_MDS);
        for (int i = 1; i <= 4; i++) step("mul_wait", 0, 0, 0, nop, mul, C_MDW);
        step("mul_release", 0, 0, 1, nop, mul, C_REL);
        step("rdy_in_run", 0, 0, 1, nop, nop, C_NORM);

        step("div_start", 0, 0, 0, nop, dv, C_MDS);
        step("div_wait1", 0, 0, 0, nop, dv, C_MDW);
        step("div_br_ignored", 0, 1, 0, nop, dv, C_MDW);
        for (int i = 3; i <= 39; i++) step("div_wait", 0, 0, 0, nop, dv, C_MDW);
        step("div_timeout", 0, 0, 0, nop, dv, C_TMO);
        step("post_timeout", 0, 0, 0, nop, nop, C_NORM);

        step("div2_start", 0, 0, 0, nop, dv, C_MDS);
        for (int i = 1; i <= 39; i++) step("div2_wait", 0, 0, 0, nop, dv, C_MDW);
        step("rdy_and_tmo", 0, 0, 1, nop, dv, C_REL);
        step("relaunch", 0, 0, 0, nop, mul, C_MDS);
        step("rdy_first", 0, 0, 1, nop, mul, C_REL);
        step("idle2", 0, 0, 0, nop, nop, C_NORM);

        step("abort_start", 0, 0, 0, nop, mul, C_MDS);
        step("abort_w1", 0, 0, 0, nop, mul, C_MDW);
        step("abort_w2", 0, 0, 0, nop, mul, C_MDW);
        step("abort_reset", 1, 0, 0, nop, mul, C_RST);
        step("late_rdy", 0, 0, 1, nop, nop, C_NORM);
        step("after_abort", 0, 0, 0, nop, nop, C_NORM);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
